// File: rtl/packer_pkg.sv
// Shared defaults and small helpers for the packer block.
package packer_pkg;

  localparam int unsigned DefaultUnpackedWidth = 32'd2;
  localparam int unsigned DefaultPackedNum     = 32'd4;

  // A word closes when the element lands in the top lane or carries last.
  function automatic logic word_closes(input logic at_last_lane, input logic last);
    return at_last_lane | last;
  endfunction

endpackage

// File: rtl/counter_roll.sv
// Rolling counter: 0..max_val_i, wraps to zero, with a synchronous clear.
module counter_roll #(
  parameter int unsigned Width = 32'd2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_val_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; increment wraps at max_val_i.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == max_val_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + One;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_reg.sv
// Single-entry elastic output register with valid/ready on both sides.
module elastic_reg #(
  parameter int unsigned Width         = 32'd8,
  parameter bit          DatapathGate  = 1'b1,
  parameter bit          DatapathReset = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             load_s;

  // Room exists when empty or when the held entry leaves this cycle.
  assign ready_o = !valid_q || ready_i;
  assign load_s  = valid_i && ready_o;

  // Next valid and data; gating keeps data frozen unless a real load happens.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_s) begin
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (DatapathGate) begin
      data_d = load_s ? data_i : data_q;
    end else begin
      data_d = ready_o ? data_i : data_q;
    end
  end

  // Entry register; data also clears on reset when configured to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      if (DatapathReset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/packer.sv
// Packs narrow elements LSB-first into wide words, with early flush on last_i.
module packer
  import packer_pkg::*;
#(
  parameter  int unsigned UnpackedWidth = DefaultUnpackedWidth,
  parameter  int unsigned PackedNum     = DefaultPackedNum,
  localparam int unsigned PackedWidth   = UnpackedWidth * PackedNum,
  localparam int unsigned LanesWidth    = $clog2(PackedNum + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [UnpackedWidth-1:0] unpacked_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  output logic                     ready_o,
  output logic [PackedWidth-1:0]   packed_o,
  output logic [LanesWidth-1:0]    lanes_o,
  output logic                     last_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int unsigned CountWidth = $clog2(PackedNum);
  localparam int unsigned RegWidth   = PackedWidth + LanesWidth + 1;
  localparam logic [CountWidth-1:0] MaxLane = CountWidth'(PackedNum - 1);

  logic [CountWidth-1:0]  cnt_s;
  logic                   at_last_lane_s;
  logic                   closes_next_s;
  logic                   reg_ready_s;
  logic                   in_fire_s;
  logic                   close_s;
  logic [PackedWidth-1:0] lane_val_s;
  logic [PackedWidth-1:0] word_s;
  logic [LanesWidth-1:0]  lanes_s;
  logic [PackedWidth-1:0] acc_q, acc_d;
  logic [RegWidth-1:0]    reg_in_s, reg_out_s;

  assign at_last_lane_s = (cnt_s == MaxLane);
  assign closes_next_s  = word_closes(at_last_lane_s, last_i);

  // Non-closing elements never wait; closing ones need room in the output register.
  assign ready_o   = !closes_next_s || reg_ready_s;
  assign in_fire_s = valid_i && ready_o;
  assign close_s   = in_fire_s && closes_next_s;

  // Place the element in its lane and merge with lanes already collected.
  assign lane_val_s = PackedWidth'(unpacked_i) << (cnt_s * UnpackedWidth);
  assign word_s     = acc_q | lane_val_s;
  assign lanes_s    = LanesWidth'(cnt_s) + LanesWidth'(1);

  counter_roll #(
    .Width (CountWidth)
  ) u_lane_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (close_s && !at_last_lane_s),
    .en_i      (in_fire_s),
    .max_val_i (MaxLane),
    .cnt_o     (cnt_s)
  );

  // Accumulator: collect lanes, empty it whenever a word is handed off.
  always_comb begin
    acc_d = acc_q;
    if (in_fire_s) begin
      if (close_s) begin
        acc_d = '0;
      end else begin
        acc_d = word_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign reg_in_s = {last_i, lanes_s, word_s};

  elastic_reg #(
    .Width         (RegWidth),
    .DatapathGate  (1'b1),
    .DatapathReset (1'b1)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (close_s),
    .ready_o (reg_ready_s),
    .data_i  (reg_in_s),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (reg_out_s)
  );

  assign packed_o = reg_out_s[PackedWidth-1:0];
  assign lanes_o  = reg_out_s[PackedWidth +: LanesWidth];
  assign last_o   = reg_out_s[RegWidth-1];

endmodule

// File: tb/tb_packer.sv
// Self-checking bench for packer (2-bit elements, 4 lanes).
module tb_packer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] unpacked_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic [7:0] packed_o;
  logic [2:0] lanes_o;
  logic       last_o;
  logic       valid_o;
  logic       ready_i;

  packer #(.UnpackedWidth(2), .PackedNum(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .unpacked_i (unpacked_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .ready_o    (ready_o),
    .packed_o   (packed_o),
    .lanes_o    (lanes_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] pk;
    int         lanes;
    bit         lst;
  } word_t;

  word_t exp_q[$];
  int    part_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    fire_cnt = 0;
  int    stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words are lists of accepted elements, cut at 4 or at last.
  always @(negedge clk_i) begin
    bit    exp_rdy;
    word_t w;
    check("valid_o", valid_o, exp_q.size() != 0);
    if (valid_i && !rst_i) begin
      exp_rdy = !(part_q.size() == 3 || last_i) || exp_q.size() == 0 || ready_i;
      check("ready_o", ready_o, exp_rdy);
    end
    if (valid_o && exp_q.size() != 0) begin
      check("model packed_o", packed_o, exp_q[0].pk);
      check("model lanes_o", lanes_o, exp_q[0].lanes);
      check("model last_o", last_o, exp_q[0].lst);
    end
    if (rst_i) begin
      exp_q.delete();
      part_q.delete();
    end else begin
      if (valid_o && ready_i && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        fire_cnt++;
      end
      if (valid_i && ready_o) begin
        part_q.push_back(int'(unpacked_i));
        if (part_q.size() == 4 || last_i) begin
          w.pk = 8'd0;
          for (int k = 0; k < part_q.size(); k++) begin
            w.pk = w.pk | (8'(part_q[k]) << (2 * k));
          end
          w.lanes = part_q.size();
          w.lst   = last_i;
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  end

  // Present one element and hold it until accepted (bounded wait).
  task automatic send(input logic [1:0] d, input bit l);
    int budget = 0;
    valid_i    = 1'b1;
    unpacked_i = d;
    last_i     = l;
    @(negedge clk_i);
    while (!ready_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    stalls += budget;
    if (!ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send timeout: ready_o stuck at 0, expected 1");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    last_i  = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; unpacked_i = 2'd0; ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst valid_o", valid_o, 1'b0);
    check("rst packed_o", packed_o, 8'h00);
    check("rst lanes_o", lanes_o, 3'd0);
    check("rst last_o", last_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check("post-rst ready_o", ready_o, 1'b1);

    // Full word 1,2,3,0
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
    valid_i = 1'b0;
    check("full valid_o", valid_o, 1'b1);
    check("full packed_o", packed_o, 8'h39);
    check("full lanes_o", lanes_o, 3'd4);
    check("full last_o", last_o, 1'b0);
    idle(1);
    check("drained valid_o", valid_o, 1'b0);

    // Flush: 3 then 1+last, then a lane-0 last word
    send(2'd3, 1'b0); send(2'd1, 1'b1);
    check("flush packed_o", packed_o, 8'h07);
    check("flush lanes_o", lanes_o, 3'd2);
    check("flush last_o", last_o, 1'b1);
    send(2'd2, 1'b1);
    check("lane0 packed_o", packed_o, 8'h02);
    check("lane0 lanes_o", lanes_o, 3'd1);
    check("lane0 last_o", last_o, 1'b1);
    idle(2);

    // Backpressure
    ready_i = 1'b0;
    send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0);
    check("held packed_o", packed_o, 8'h55);
    send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
    valid_i = 1'b1; unpacked_i = 2'd3; last_i = 1'b0;
    #1;
    check("bp ready_o low", ready_o, 1'b0);
    @(posedge clk_i);
    #1;
    check("bp held stable", packed_o, 8'h55);
    check("bp held valid", valid_o, 1'b1);
    ready_i = 1'b1;
    #1;
    check("bp ready_o high", ready_o, 1'b1);
    send(2'd3, 1'b0);
    check("bp new valid_o", valid_o, 1'b1);
    check("bp new packed_o", packed_o, 8'hEA);
    check("bp new lanes_o", lanes_o, 3'd4);
    idle(2);

    // Streaming 16 elements
    stalls = 0;
    f0 = fire_cnt;
    for (int i = 0; i < 16; i++) send(2'(i % 4), 1'b0);
    idle(2);
    check("stream words", fire_cnt - f0, 4);
    check("stream stalls", stalls, 0);

    // Reset with a held word and a partial word
    ready_i = 1'b0;
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
    send(2'd2, 1'b0); send(2'd2, 1'b0);
    valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst valid_o", valid_o, 1'b0);
    check("midrst packed_o", packed_o, 8'h00);
    check("midrst lanes_o", lanes_o, 3'd0);
    rst_i = 1'b0;
    #1;
    check("midrst ready_o", ready_o, 1'b1);
    ready_i = 1'b1;
    send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0);
    valid_i = 1'b0;
    check("after rst packed_o", packed_o, 8'h55);
    check("after rst lanes_o", lanes_o, 3'd4);
    check("after rst last_o", last_o, 1'b0);
    idle(3);
    check("after rst idle", valid_o, 1'b0);

    // Random valid/ready/last traffic against the model
    for (int c = 0; c < 1500; c++) begin
      valid_i    = 1'($urandom_range(0, 1));
      last_i     = ($urandom_range(0, 7) == 0);
      unpacked_i = 2'($urandom_range(0, 3));
      ready_i    = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
    idle(4);
    check("random drained", valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
